imem_loader: RTL
================

Name: imem_loader

Overview:
- Instruction-memory and program-loader stage that sits directly upstream of the SEQ fetch stage.
- Accepts a Y86 program as a byte stream over a valid/ready handshake and stores it in byte-addressed memory.
- Releases the core once the program is loaded.
- Each cycle, serves fetch a registered 10-byte instruction window at the current PC.
- Stops serving when fetch reports halt.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, width of the load pointer and length counter. Must satisfy 2^ADDR_W >= MEM_BYTES.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a program load.
- ld_valid  input  1  load byte valid.
- ld_byte  input  8  load data byte.
- ld_last  input  1  marks the final byte of the program; qualified by ld_valid.
- ld_ready  output  1  loader can accept a byte.
- PC  input  64  fetch address from PC update.
- hlt  input  1  halt indication from fetch.
- instr  output  80  instruction window: instr[7:0] = mem[PC], instr[15:8] = mem[PC+1], …, instr[79:72] = mem[PC+9].
- imem_error  output  1  fetch window partly or fully outside MEM_BYTES.
- run  output  1  core enable.
- load_err  output  1  program overflowed memory.
- load_len  output  ADDR_W+1  number of bytes loaded.
- state  output  2  IDLE=0, LOAD=1, RUN=2, HALTED=3.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ld_ready=0, run=0, load_err=0, load_len=0, instr=0, imem_error=0.
  - Memory array is not cleared.
- Read masking: any byte at address >= load_len reads as 8'h00. Unloaded space therefore decodes as halt (icode 0).
- IDLE:
  - start → LOAD on the next edge.
  - ld_valid is ignored.
- LOAD:
  - Entry clears load_len to 0 and load_err to 0.
  - ld_ready=1 combinationally while in LOAD and load_err=0.
  - A byte transfers on a posedge with ld_valid & ld_ready: mem[load_len] <= ld_byte, then load_len increments.
  - A transfer with ld_last=1 → RUN on that edge.
  - A transfer with ld_last=0 when load_len == MEM_BYTES-1:
    - The byte is written and load_len becomes MEM_BYTES.
    - load_err becomes 1, ld_ready drops, state → HALTED.
  - start during LOAD is ignored.
  - ld_valid without ld_ready never writes.
- RUN:
  - run=1.
  - Every posedge registers instr from the 10 bytes at PC..PC+9, applying read masking. Latency is 1 cycle from PC to instr.
  - imem_error is registered in the same cycle as instr: it is 1 when PC > MEM_BYTES-10, compared as full 64-bit unsigned. In that case instr = 0 for the whole window.
  - hlt=1 sampled at a posedge → HALTED on that edge. run drops and instr holds its last value.
  - hlt and a PC change in the same cycle: hlt wins and instr is not updated.
- HALTED:
  - run=0, ld_ready=0.
  - instr, imem_error and load_len hold.
  - start → LOAD.
  - load_err holds until LOAD entry.
- Simultaneous events:
  - start in RUN is ignored. Only hlt or reset leaves RUN.
  - Reset mid-load returns to IDLE with load_len=0. Previously written bytes remain in the array but are masked.
- Width rules:
  - PC+k is computed in 64 bits.
  - Address comparison uses the full PC, with no truncation to ADDR_W before the bounds check.

Test Plan:
- Reset then start; stream 10 bytes 30 F2 0A 00 00 00 00 00 00 00 with ld_last on the 10th → state=RUN one cycle after the last transfer, load_len=10, run=1. With PC=0, the next edge gives instr = 80'h000000000000000AF230 and imem_error=0.
- Load 1 byte 10 (nop), PC=0 → instr = 80'h10 with upper bytes zero (masked). Then PC=1 → instr=0.
- Handshake stalls: toggle ld_valid low for 3 cycles mid-stream → no writes during the gap and load_len unchanged. Hold ld_valid high in IDLE → ld_ready=0 and load_len stays 0.
- Overflow with MEM_BYTES=16: stream 16 bytes without ld_last → load_err=1, load_len=16, state=HALTED, ld_ready=0 after the 16th byte.
- PC=MEM_BYTES-9 in RUN → imem_error=1 and instr=0 on the next edge. Assert hlt → state=HALTED, run=0, instr holds. Pulse start → LOAD with load_len=0 and load_err=0.
- Assert rst_n=0 mid-load after 5 bytes, asynchronously between edges → ld_ready, run and load_len go to 0 immediately and state=IDLE.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream load channel into the instruction memory loader.
// A byte moves on a posedge where ld_valid and ld_ready are both high; ld_last is only meaningful with ld_valid.
interface imem_loader_if;
  logic       ld_valid;
  logic [7:0] ld_byte;
  logic       ld_last;
  logic       ld_ready;

  modport master (output ld_valid, ld_byte, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_byte, ld_last, output ld_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a streaming program loader; serves SEQ fetch a registered
// 10-byte window at PC while running and stops on halt.
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_loader_if.slave        ld,
    input  logic [63:0]         PC,
    input  logic                hlt,
    output logic [79:0]         instr,
    output logic                imem_error,
    output logic                run,
    output logic                load_err,
    output logic [ADDR_W:0]     load_len,
    output logic [1:0]          state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // Highest PC whose whole 10-byte window still lies inside the array.
    localparam logic [63:0]     LAST_PC    = 64'(MEM_BYTES) - 64'd10;
    localparam logic [ADDR_W:0] LEN_LAST_B = (ADDR_W + 1)'(MEM_BYTES - 1);

    logic [7:0]  mem [MEM_BYTES];
    logic        xfer;
    logic [79:0] win;
    logic        win_err;

    assign ld.ld_ready = (state == S_LOAD) && !load_err;
    assign xfer        = ld.ld_valid && ld.ld_ready;
    assign run         = (state == S_RUN);

    // Bytes at or beyond load_len read as zero so unloaded space decodes as halt.
    always_comb begin
        win     = '0;
        win_err = (PC > LAST_PC);
        for (int k = 0; k < 10; k++) begin
            if (!win_err && ((PC + 64'(k)) < 64'(load_len)))
                win[8*k +: 8] = mem[ADDR_W'(PC + 64'(k))];
        end
    end

    always_ff @(posedge clk) begin
        if (xfer)
            mem[load_len[ADDR_W-1:0]] <= ld.ld_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            load_err   <= 1'b0;
            load_len   <= '0;
            instr      <= '0;
            imem_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state    <= S_LOAD;
                        load_len <= '0;
                        load_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        load_len <= load_len + 1'b1;
                        if (ld.ld_last) begin
                            state <= S_RUN;
                        end else if (load_len == LEN_LAST_B) begin
                            load_err <= 1'b1;
                            state    <= S_HALTED;
                        end
                    end
                end
                S_RUN: begin
                    if (hlt) begin
                        state <= S_HALTED;
                    end else begin
                        instr      <= win;
                        imem_error <= win_err;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
